// File: rtl/sign_narrower.sv
// Narrows 32-bit values to 16 bits (signed or unsigned range, wrap or saturate)
// and queues the results with their overflow flags in a small FIFO.
module sign_narrower #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             mode_signed,
  input  logic             mode_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_ovf,
  input  logic             clear_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

  occ_t             state_reg, state_next;
  logic [OCC_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] ovf_count_reg, ovf_count_next;

  logic             ovf_in;
  logic [15:0]      res_in;
  logic             push, pop;
  logic [16:0]      mem [DEPTH];
  logic [16:0]      head;

  // Range check and result selection for the value currently presented.
  always_comb begin
    if (mode_signed) begin
      ovf_in = !((&in_data[31:15]) || !(|in_data[31:15]));
    end else begin
      ovf_in = |in_data[31:16];
    end
    res_in = in_data[15:0];
    if (mode_sat && ovf_in) begin
      if (!mode_signed) begin
        res_in = 16'hFFFF;
      end else if (in_data[31]) begin
        res_in = 16'h8000;
      end else begin
        res_in = 16'h7FFF;
      end
    end
  end

  // Ready is held low while reset is asserted; otherwise it depends only on state.
  assign in_ready  = rst_n && (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {ovf_in, res_in};
    end
  end

  assign head     = mem[rd_ptr_reg];
  assign out_data = out_valid ? head[15:0] : 16'h0000;
  assign out_ovf  = out_valid ? head[16]   : 1'b0;

  always_comb begin
    count_next     = count_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    state_next     = state_reg;
    ovf_count_next = ovf_count_reg;

    case ({push, pop})
      2'b10:   count_next = count_reg + OCC_W'(1);
      2'b01:   count_next = count_reg - OCC_W'(1);
      default: count_next = count_reg;
    endcase

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
    end

    if (count_next == '0) begin
      state_next = EMPTY;
    end else if (count_next == OCC_FULL) begin
      state_next = FULL;
    end else begin
      state_next = PARTIAL;
    end

    if (clear_count) begin
      ovf_count_next = '0;
    end else if (push && ovf_in && (ovf_count_reg != CNT_MAX)) begin
      ovf_count_next = ovf_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      ovf_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      ovf_count_reg <= ovf_count_next;
    end
  end

  assign ovf_count = ovf_count_reg;

endmodule

// File: doc/sign_narrower.md
SIGN_NARROWER -- requirements
Module: sign_narrower

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the output queue depth in entries; legal values are 2 to 8.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the overflow event counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  input  1  is the rising-edge clock for all state.
REQ-005 rst_n  input  1  is the asynchronous active-low reset.
REQ-006 in_valid  input  1  marks that the producer is presenting a value.
REQ-007 in_ready  output  1  marks that the block can accept a value this cycle.
REQ-008 in_data  input  32  is the value to narrow.
REQ-009 mode_signed  input  1  selects the range: 1 = signed 16-bit, 0 = unsigned 16-bit.
REQ-010 mode_sat  input  1  selects the out-of-range action: 1 = saturate, 0 = wrap (truncate).
REQ-011 out_valid  output  1  marks that the queue head is presented.
REQ-012 out_ready  input  1  marks that the consumer is taking the head.
REQ-013 out_data  output  16  is the narrowed result.
REQ-014 out_ovf  output  1  marks that the head input was outside the selected range.
REQ-015 clear_count  input  1  is a synchronous clear of ovf_count.
REQ-016 ovf_count  output  CNT_W  is the saturating count of accepted out-of-range inputs.

Function
REQ-017 An input SHALL be accepted on a rising clk edge where in_valid and in_ready are both 1; in_data, mode_signed and mode_sat SHALL be sampled together at that edge.
REQ-018 Out-of-range detection for signed mode SHALL be: ovf = NOT (in_data[31:15] all-zero or all-one).
REQ-019 Out-of-range detection for unsigned mode SHALL be: ovf = (in_data[31:16] != 0).
REQ-020 In wrap mode, or whenever ovf = 0, the result SHALL be in_data[15:0].
REQ-021 In saturate mode with ovf = 1, the result SHALL be: signed with in_data[31] = 0 gives 0x7FFF; signed with in_data[31] = 1 gives 0x8000; unsigned gives 0xFFFF.
REQ-022 Each result SHALL be written, together with its ovf flag, into a FIFO of DEPTH entries and delivered in acceptance order.
REQ-023 The FIFO SHALL track occupancy as EMPTY (count 0), PARTIAL (0 < count < DEPTH) and FULL (count = DEPTH).
REQ-024 The FIFO state SHALL move only by push (accept), pop (out_valid and out_ready), or both together, in which case count is unchanged.
REQ-025 in_ready SHALL equal (count < DEPTH), decoded from registered state only, with no combinational path from out_ready.
REQ-026 out_valid SHALL equal (count != 0).
REQ-027 Latency SHALL be 1 cycle: a value accepted at edge N into an empty FIFO has out_valid = 1 after edge N.
REQ-028 While out_valid = 1 and out_ready = 0, out_data and out_ovf SHALL hold stable.
REQ-029 While FULL, no push SHALL occur; a pop at FULL SHALL raise in_ready in the following cycle.
REQ-030 Push and pop in the same cycle from PARTIAL SHALL be legal; the read and write pointers SHALL wrap modulo DEPTH independently.
REQ-031 ovf_count SHALL increment by 1 on each accepted input with ovf = 1, and SHALL hold at 2^CNT_W-1 instead of wrapping.
REQ-032 When clear_count = 1, ovf_count SHALL become 0 at the next edge; clear SHALL take priority over a simultaneous increment.
REQ-033 out_data and out_ovf SHALL be 0 whenever out_valid = 0.

Reset
REQ-034 Assertion of rst_n = 0 SHALL immediately, without a clock edge, force count = 0, both pointers = 0, out_valid = 0, out_data = 0, out_ovf = 0 and ovf_count = 0.
REQ-035 While rst_n = 0, in_ready SHALL be 0; it SHALL become 1 in the first cycle after rst_n deasserts.
REQ-036 Reset asserted mid-stream SHALL discard all queued entries; no stale entry SHALL appear after release.

Verification
REQ-037 Signed saturate, out_ready = 1: inputs 0x00012345, 0xFFFF8000, 0xFFFEFFFF -> outputs 0x7FFF/ovf 1, 0x8000/ovf 0, 0x8000/ovf 1; each appears 1 cycle after its acceptance; ovf_count = 2.
REQ-038 Unsigned wrap: input 0x0001ABCD -> output 0xABCD with ovf 1; input 0x0000FFFF -> output 0xFFFF with ovf 0.
REQ-039 Backpressure, DEPTH = 2, out_ready = 0: third in_valid sees in_ready = 0 after 2 accepts; out_data holds the first value; after one out_ready pulse, in_ready = 1 next cycle; order preserved.
REQ-040 Counter: 300 overflowing inputs -> ovf_count = 255; clear_count coincident with an overflowing accept -> ovf_count = 0.
REQ-041 Reset with 2 entries queued: out_valid = 0 and ovf_count = 0 immediately; after release, in_ready = 1 and no old data emerges.
